// File: rtl/fp_seq_multiplier_if.sv
// Handshake and operand/result bundle for fp_seq_multiplier.
// master drives the request side; slave is the multiplier itself.
interface fp_seq_multiplier_if #(
  parameter int W_in  = 16,
  parameter int W_out = 16
);
  logic              start;
  logic [W_in-1:0]   a;
  logic [W_in-1:0]   b;
  logic [W_out-1:0]  product;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              underflow;

  modport master (
    output start, a, b,
    input  product, busy, done, overflow, underflow
  );

  modport slave (
    input  start, a, b,
    output product, busy, done, overflow, underflow
  );
endinterface

// File: rtl/fp_seq_multiplier.sv
// Shift-add signed fixed-point multiplier: one partial product per clock on
// operand magnitudes, then round-half-away and saturate to the output format.
module fp_seq_multiplier #(
  parameter int W_in    = 16,
  parameter int W_in_F  = 14,
  parameter int W_out   = 16,
  parameter int W_out_F = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_seq_multiplier_if.slave  bus
);

  localparam int CNT_W = $clog2(W_in);
  localparam int AW    = 2 * W_in + 1;
  localparam int S     = 2 * W_in_F - W_out_F;
  localparam int S_M1  = (S > 0) ? S - 1 : 0;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(W_in - 1);
  localparam logic [AW-1:0]    ONE     = AW'(1);
  localparam logic [AW-1:0]    LIM_NEG = ONE << (W_out - 1);
  localparam logic [AW-1:0]    LIM_POS = LIM_NEG - ONE;
  localparam logic [AW-1:0]    RND     = (S > 0) ? (ONE << S_M1) : '0;

  typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

  state_t              state_q;
  logic [W_in-1:0]     a_mag_q, b_mag_q;
  logic                sign_q;
  logic [2*W_in-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [W_out-1:0]    product_q;
  logic                busy_q, done_q, overflow_q, underflow_q;

  logic [W_in-1:0]     a_mag_d, b_mag_d;
  logic [2*W_in-1:0]   partial;
  logic [AW-1:0]       rounded, mag;
  logic [W_out-1:0]    product_d;
  logic                overflow_d, underflow_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_mag_d     = bus.a[W_in-1] ? (~bus.a + W_in'(1)) : bus.a;
    b_mag_d     = bus.b[W_in-1] ? (~bus.b + W_in'(1)) : bus.b;
    partial     = {{W_in{1'b0}}, a_mag_q} << cnt_q;
    rounded     = {1'b0, acc_q} + RND;
    mag         = rounded >> S;
    product_d   = '0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    // Saturation is decided on the rounded magnitude; the negative side
    // reaches one step further because -2^(W_out-1) is representable.
    if (!sign_q) begin
      if (mag > LIM_POS) begin
        product_d  = {1'b0, {(W_out-1){1'b1}}};
        overflow_d = 1'b1;
      end else begin
        product_d  = mag[W_out-1:0];
      end
    end else if (mag > LIM_NEG) begin
      product_d   = {1'b1, {(W_out-1){1'b0}}};
      underflow_d = 1'b1;
    end else begin
      product_d   = -mag[W_out-1:0];
    end
  end

  // NOTE: state is only ever written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      sign_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            sign_q  <= bus.a[W_in-1] ^ bus.b[W_in-1];
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (b_mag_q[cnt_q]) acc_q <= acc_q + partial;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_q <= FINAL;
        end
        FINAL: begin
          product_q   <= product_d;
          overflow_q  <= overflow_d;
          underflow_q <= underflow_d;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.product   = product_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_fp_seq_multiplier.sv
// Randomized and directed bench for fp_seq_multiplier against an
// integer-arithmetic reference of the fixed-point product.
module tb_fp_seq_multiplier;

  localparam int W_IN    = 16;
  localparam int W_IN_F  = 14;
  localparam int W_OUT   = 16;
  localparam int W_OUT_F = 14;
  localparam int LAT     = W_IN + 1;
  localparam int S       = 2 * W_IN_F - W_OUT_F;

  typedef struct packed {
    logic [W_OUT-1:0] p;
    logic             ovf;
    logic             unf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_seq_multiplier_if #(.W_in(W_IN), .W_out(W_OUT)) bus ();

  fp_seq_multiplier #(
    .W_in(W_IN), .W_in_F(W_IN_F), .W_out(W_OUT), .W_out_F(W_OUT_F)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Exact product, rounded half away from zero on the magnitude, then clamped.
  function automatic res_t ref_mul(input logic [W_IN-1:0] a, input logic [W_IN-1:0] b);
    res_t   r;
    longint pa, pb, p, mag, m, lim;
    pa  = longint'($signed(a));
    pb  = longint'($signed(b));
    p   = pa * pb;
    mag = (p < 0) ? -p : p;
    m   = (S > 0) ? ((mag + (longint'(1) << (S - 1))) >> S) : mag;
    lim = longint'(1) << (W_OUT - 1);
    r   = '0;
    if (p >= 0) begin
      if (m > lim - 1) begin r.p = W_OUT'(lim - 1); r.ovf = 1'b1; end
      else r.p = W_OUT'(m);
    end else begin
      if (m > lim) begin r.p = W_OUT'(lim); r.unf = 1'b1; end
      else r.p = W_OUT'(-m);
    end
    return r;
  endfunction

  res_t exp_q[$];
  int   acc_cyc_q[$];
  res_t held;
  logic done_prev;

  // Scoreboard: watches accepted starts and every result, away from the edge.
  always @(negedge clk) begin
    res_t e;
    int   ac;
    if (!rst_n) begin
      exp_q.delete();
      acc_cyc_q.delete();
      held      = '0;
      done_prev = 1'b0;
    end else begin
      if (bus.done) begin
        check("done_width", 32'(done_prev), 0);
        if (exp_q.size() == 0) begin
          check("stale_done", 32'(bus.done), 0);
        end else begin
          e  = exp_q.pop_front();
          ac = acc_cyc_q.pop_front();
          check("latency", cyc - ac, LAT);
          check("product", 32'(bus.product), 32'(e.p));
          check("overflow", 32'(bus.overflow), 32'(e.ovf));
          check("underflow", 32'(bus.underflow), 32'(e.unf));
          held = e;
        end
      end else begin
        check("hold_product", 32'(bus.product), 32'(held.p));
        check("hold_flags", {30'b0, bus.overflow, bus.underflow}, {30'b0, held.ovf, held.unf});
      end
      check("busy", 32'(bus.busy), 32'(exp_q.size() > 0));
      if (!bus.busy && bus.start) begin
        exp_q.push_back(ref_mul(bus.a, bus.b));
        acc_cyc_q.push_back(cyc + 1);
      end
      done_prev = bus.done;
    end
  end

  task automatic run_op(input logic [W_IN-1:0] a, input logic [W_IN-1:0] b);
    for (int i = 0; i < 4 * LAT && bus.busy; i++) begin
      @(posedge clk); #1;
    end
    check("idle_before_start", 32'(bus.busy), 0);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = W_IN'($urandom);
    bus.b     = W_IN'($urandom);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 5 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'(bus.done), 1);
  endtask

  task automatic run_exp(input string tag, input logic [W_IN-1:0] a, input logic [W_IN-1:0] b,
                         input logic [W_OUT-1:0] ep, input logic eo, input logic eu);
    run_op(a, b);
    wait_done();
    check(tag, 32'(bus.product), 32'(ep));
    check({tag, "_flags"}, {30'b0, bus.overflow, bus.underflow}, {30'b0, eo, eu});
  endtask

  function automatic logic [W_IN-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return W_IN'($urandom);
    endcase
  endfunction

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    check("rst_product", 32'(bus.product), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_underflow", 32'(bus.underflow), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_exp("half_x_m175", 16'h2000, 16'h9000, 16'hC800, 1'b0, 1'b0);
    run_exp("sat_pos",     16'h6000, 16'h6000, 16'h7FFF, 1'b1, 1'b0);
    run_exp("m2_x_m2",     16'h8000, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    run_exp("sat_neg",     16'h9000, 16'h6000, 16'h8000, 1'b0, 1'b1);
    run_exp("exact_min",   16'h8000, 16'h4000, 16'h8000, 1'b0, 1'b0);
    run_exp("round_pos",   16'h0001, 16'h2000, 16'h0001, 1'b0, 1'b0);
    run_exp("round_neg",   16'hFFFF, 16'h2000, 16'hFFFF, 1'b0, 1'b0);
    run_exp("zero",        16'h0000, 16'h9000, 16'h0000, 1'b0, 1'b0);

    // Abort partway through the iterations; nothing from it may surface later.
    run_op(16'h4000, 16'h7000);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_product", 32'(bus.product), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_flags", {30'b0, bus.overflow, bus.underflow}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_exp("after_abort", 16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0);

    // start held high with operands changing every cycle.
    for (int i = 0; i < 6 * (LAT + 1); i++) begin
      bus.start = 1'b1;
      bus.a     = pick();
      bus.b     = pick();
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("drained", 32'(bus.busy), 0);

    for (int i = 0; i < 40; i++) begin
      run_op(pick(), pick());
      wait_done();
    end

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
